bist_pattern_misr: RTL

BIST datapath downstream of the BIST sequencing controller. Consumes the controller's registered `init`/`running`/`mode`/`finish` strobes. Generates pseudo-random test patterns with a Galois LFSR and compacts DUT responses into a signature with a MISR. At end of test, compares the signature against a golden value and latches pass/fail.

---
 rtl/bist_pkg.sv | 15 +
 rtl/galois_shift_reg.sv | 33 +++
 rtl/bist_pattern_misr.sv | 122 ++++++++++++
 3 files changed

// File: rtl/bist_pkg.sv
// Shared types and default constants for the BIST pattern generator / response compactor.
package bist_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } bist_state_e;

  localparam logic [7:0] LFSR_POLY_DEF = 8'h1D;
  localparam logic [7:0] MISR_POLY_DEF = 8'h1D;
  localparam logic [7:0] LFSR_SEED_DEF = 8'h01;

endpackage

// File: rtl/galois_shift_reg.sv
// MSB-out Galois shift register with XOR input; used both as pattern LFSR (din=0) and as MISR.
module galois_shift_reg #(
  parameter int               WIDTH = 8,
  parameter logic [WIDTH-1:0] POLY  = '0
) (
  input  logic             clock,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             en,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // No reset port: the owner clears the register by pulsing load with a zero load_val.
  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = load_val;
    end else if (en) begin
      q_d = {q_q[WIDTH-2:0], 1'b0} ^ (q_q[WIDTH-1] ? POLY : '0) ^ din;
    end
  end

  always_ff @(posedge clock) begin
    q_q <= q_d;
  end

  assign q = q_q;

endmodule

// File: rtl/bist_pattern_misr.sv
// BIST datapath: LFSR pattern source, MISR response compactor, and end-of-test pass/fail latch.
module bist_pattern_misr
  import bist_pkg::*;
#(
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] LFSR_POLY  = WIDTH'(LFSR_POLY_DEF),
  parameter logic [WIDTH-1:0] LFSR_SEED  = WIDTH'(LFSR_SEED_DEF),
  parameter logic [WIDTH-1:0] MISR_POLY  = WIDTH'(MISR_POLY_DEF),
  parameter logic [WIDTH-1:0] GOLDEN_SIG = '0,
  parameter int               CNT_W      = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             init,
  input  logic             running,
  input  logic             mode,
  input  logic             finish,
  input  logic [WIDTH-1:0] dut_response,
  output logic [WIDTH-1:0] pattern,
  output logic [WIDTH-1:0] signature,
  output logic [CNT_W-1:0] vec_count,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output bist_state_e      state_o
);

  // An all-zero seed would lock the LFSR at zero forever.
  localparam logic [WIDTH-1:0] SEED_EFF = (LFSR_SEED == '0) ? WIDTH'(1) : LFSR_SEED;

  bist_state_e      state_q;
  logic [CNT_W-1:0] vec_count_q;
  logic [CNT_W-1:0] vec_count_d;
  logic             done_q;
  logic             pass_q;
  logic             fail_q;

  logic             active;
  logic             compact;
  logic             sr_load;
  logic [WIDTH-1:0] lfsr_load_val;
  logic             sig_match;

  // Controller strobes are single-cycle levels sampled every edge; priority is
  // init > finish > (running & mode), and compaction happens only in ARMED/RUN.
  assign active        = (state_q == ARMED) || (state_q == RUN);
  assign compact       = active && running && mode && !init && !finish;
  assign sr_load       = reset || init;
  assign lfsr_load_val = reset ? '0 : SEED_EFF;
  assign sig_match     = (signature == GOLDEN_SIG);
  assign vec_count_d   = (vec_count_q == '1) ? vec_count_q : vec_count_q + CNT_W'(1);

  galois_shift_reg #(.WIDTH(WIDTH), .POLY(LFSR_POLY)) u_lfsr (
    .clock    (clock),
    .load     (sr_load),
    .load_val (lfsr_load_val),
    .en       (compact),
    .din      ('0),
    .q        (pattern)
  );

  galois_shift_reg #(.WIDTH(WIDTH), .POLY(MISR_POLY)) u_misr (
    .clock    (clock),
    .load     (sr_load),
    .load_val ('0),
    .en       (compact),
    .din      (dut_response),
    .q        (signature)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      vec_count_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else if (init) begin
      state_q     <= ARMED;
      vec_count_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
      fail_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          // finish without a prior init is a controller protocol error
          if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= 1'b0;
            fail_q  <= 1'b1;
          end
        end
        ARMED, RUN: begin
          if (finish) begin
            state_q <= DONE;
            done_q  <= 1'b1;
            pass_q  <= sig_match;
            fail_q  <= !sig_match;
          end else if (running && mode) begin
            state_q     <= RUN;
            vec_count_q <= vec_count_d;
          end
        end
        DONE: begin
          state_q <= DONE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign vec_count = vec_count_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail      = fail_q;
  assign state_o   = state_q;

endmodule
